conv_window_3x3: RTL and testbench

// - Downstream of the line-buffer controller. Takes one 3-pixel column per beat
//   (top/centre/bottom rows, from two line buffers plus the live row) and emits
//   the 3x3 neighbourhood centred on each column.
// - Applies border padding: left/right in-block, top/bottom via row-valid qualifiers.
// - One registered output stage with valid/ready backpressure.

---
 rtl/conv_window_3x3_pkg.sv | 24 ++
 rtl/conv_window_3x3_if.sv | 28 ++
 rtl/conv_window_3x3_pad.sv | 31 +++
 rtl/conv_window_3x3.sv | 129 ++++++++++++
 tb/tb_conv_window_3x3.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_window_3x3_pkg.sv
// Shared types for the 3x3 window former: pixel, column and window containers plus FSM states.
package conv_pkg;

  localparam int PIXEL_W     = 8;
  localparam int IMAGE_MAX_W = 1920;

  typedef logic [PIXEL_W-1:0] pixel_t;
  typedef pixel_t [2:0]       column_t;
  typedef pixel_t [2:0][2:0]  window_t;

  typedef enum logic [1:0] {IDLE, PRIME, STREAM, FLUSH} window_state_t;

  // Builds a window indexed [row][col] from three columns, left to right.
  function automatic window_t make_window(column_t left, column_t mid, column_t right);
    window_t w;
    for (int r = 0; r < 3; r++) begin
      w[r][0] = left[r];
      w[r][1] = mid[r];
      w[r][2] = right[r];
    end
    return w;
  endfunction

endpackage

// File: rtl/conv_window_3x3_if.sv
// Column-in / window-out stream bundle with valid/ready on both sides.
interface conv_window_3x3_if;
  import conv_pkg::*;

  logic    in_vld;
  logic    in_rdy;
  column_t in_col;
  logic    in_top_vld;
  logic    in_bot_vld;
  logic    in_sol;
  logic    in_eol;
  logic    out_vld;
  logic    out_rdy;
  window_t out_win;
  logic    out_sol;
  logic    out_eol;

  modport master (
    output in_vld, in_col, in_top_vld, in_bot_vld, in_sol, in_eol, out_rdy,
    input  in_rdy, out_vld, out_win, out_sol, out_eol
  );

  modport slave (
    input  in_vld, in_col, in_top_vld, in_bot_vld, in_sol, in_eol, out_rdy,
    output in_rdy, out_vld, out_win, out_sol, out_eol
  );

endinterface

// File: rtl/conv_window_3x3_pad.sv
// Row-mask and edge-pad mux; CONV_WINDOW_REPLICATE_EN selects edge replication, otherwise zero padding.
module conv_window_pad
  import conv_pkg::*;
(
  input  column_t col,
  input  logic    top_vld,
  input  logic    bot_vld,
  input  column_t held,
  output column_t masked,
  output column_t lpad,
  output column_t rpad
);

`ifdef CONV_WINDOW_REPLICATE_EN
  localparam pixel_t FILL = '1;
`else
  localparam pixel_t FILL = '0;
`endif

  // FILL gates the padding source: all-ones replicates the neighbour, all-zeros forces zero.
  always_comb begin
    masked[0] = top_vld ? col[0] : (col[1] & FILL);
    masked[1] = col[1];
    masked[2] = bot_vld ? col[2] : (col[1] & FILL);
    for (int r = 0; r < 3; r++) begin
      lpad[r] = masked[r] & FILL;
      rpad[r] = held[r] & FILL;
    end
  end

endmodule

// File: rtl/conv_window_3x3.sv
// 3x3 neighbourhood former with border padding (CONV_WINDOW_REPLICATE_EN selects replicate padding).
module conv_window_3x3 #(
  parameter int IMAGE_MAX_W = conv_pkg::IMAGE_MAX_W
) (
  input  logic                    clk,
  input  logic                    rst,
  conv_window_3x3_if.slave        strm,
  output logic                    err_o
);
  import conv_pkg::*;

  localparam int CNT_W = $clog2(IMAGE_MAX_W + 1);
  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t LAST_IDX = cnt_t'(IMAGE_MAX_W - 1);
  localparam cnt_t MAX_CNT  = cnt_t'(IMAGE_MAX_W);

  window_state_t state, state_nxt;
  column_t       c0, c1;
  column_t       col_m, lpad_col, rpad_col;
  logic          sol_pend;
  cnt_t          col_cnt, cur_idx;
  logic          stall_n, accept, count_en, at_last, line_end;
  logic          load_win, start_line, shift_en, err_set;
  window_t       win_nxt;
  logic          win_sol, win_eol;

  conv_window_pad u_pad (
    .col     (strm.in_col),
    .top_vld (strm.in_top_vld),
    .bot_vld (strm.in_bot_vld),
    .held    (c1),
    .masked  (col_m),
    .lpad    (lpad_col),
    .rpad    (rpad_col)
  );

  assign stall_n     = ~strm.out_vld | strm.out_rdy;
  assign strm.in_rdy = stall_n & (state != FLUSH);
  assign accept      = strm.in_vld & strm.in_rdy;

  // cur_idx is the position of the column being accepted; hitting the last slot forces a line end.
  assign cur_idx  = strm.in_sol ? '0 : col_cnt;
  assign count_en = accept & ((state != IDLE) | strm.in_sol);
  assign at_last  = (cur_idx == LAST_IDX);
  assign line_end = strm.in_eol | at_last;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    load_win   = 1'b0;
    start_line = 1'b0;
    shift_en   = 1'b0;
    err_set    = count_en & at_last & ~strm.in_eol;
    win_nxt    = make_window(c0, c1, col_m);
    win_sol    = sol_pend;
    win_eol    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (strm.in_sol) begin
            start_line = 1'b1;
            state_nxt  = line_end ? FLUSH : PRIME;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      PRIME, STREAM: begin
        if (accept) begin
          if (strm.in_sol) begin
            err_set    = 1'b1;
            start_line = 1'b1;
            state_nxt  = line_end ? FLUSH : PRIME;
          end else begin
            load_win  = 1'b1;
            shift_en  = 1'b1;
            state_nxt = line_end ? FLUSH : STREAM;
          end
        end
      end
      FLUSH: begin
        if (stall_n) begin
          load_win  = 1'b1;
          win_nxt   = make_window(c0, c1, rpad_col);
          win_eol   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output register, column shift registers, sol tracking and column counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      strm.out_vld <= 1'b0;
      strm.out_sol <= 1'b0;
      strm.out_eol <= 1'b0;
      err_o        <= 1'b0;
      sol_pend     <= 1'b0;
      col_cnt      <= '0;
    end else begin
      if (err_set) err_o <= 1'b1;
      if (load_win) begin
        strm.out_vld <= 1'b1;
        strm.out_win <= win_nxt;
        strm.out_sol <= win_sol;
        strm.out_eol <= win_eol;
        sol_pend     <= 1'b0;
      end else if (strm.out_rdy) begin
        strm.out_vld <= 1'b0;
      end
      if (start_line) begin
        sol_pend <= 1'b1;
        c1       <= col_m;
        c0       <= lpad_col;
      end else if (shift_en) begin
        c0 <= c1;
        c1 <= col_m;
      end
      if (count_en) col_cnt <= (cur_idx == MAX_CNT) ? cur_idx : cnt_t'(cur_idx + 1'b1);
    end
  end

endmodule

// File: tb/tb_conv_window_3x3.sv
// Directed bench for conv_window_3x3 (IMAGE_MAX_W=4); expectations follow CONV_WINDOW_REPLICATE_EN.
module tb_conv_window_3x3;
  import conv_pkg::*;

`ifdef CONV_WINDOW_REPLICATE_EN
  localparam bit REPL = 1'b1;
`else
  localparam bit REPL = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic err;
  int   compare_cnt  = 0;
  int   mismatch_cnt = 0;

  window_t q_win[$];
  logic    q_sol[$];
  logic    q_eol[$];

  conv_window_3x3_if strm();

  conv_window_3x3 #(.IMAGE_MAX_W(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .strm  (strm.slave),
    .err_o (err)
  );

  always #5 clk = ~clk;

  // Records every completed output handshake; inputs only change just after posedge.
  always @(negedge clk) begin
    if (!rst && strm.out_vld && strm.out_rdy) begin
      q_win.push_back(strm.out_win);
      q_sol.push_back(strm.out_sol);
      q_eol.push_back(strm.out_eol);
    end
  end

  function automatic column_t mkcol(int top, int mid, int bot);
    column_t k;
    k[0] = pixel_t'(top);
    k[1] = pixel_t'(mid);
    k[2] = pixel_t'(bot);
    return k;
  endfunction

  function automatic column_t maskCol(column_t k, bit tv, bit bv);
    column_t m = k;
    if (!tv) m[0] = REPL ? k[1] : '0;
    if (!bv) m[2] = REPL ? k[1] : '0;
    return m;
  endfunction

  function automatic column_t edgeOf(column_t k);
    return REPL ? k : '0;
  endfunction

  function automatic window_t mkwin(column_t a, column_t b, column_t c);
    window_t w;
    for (int r = 0; r < 3; r++) begin
      w[r][0] = a[r];
      w[r][1] = b[r];
      w[r][2] = c[r];
    end
    return w;
  endfunction

  task automatic checkOutput(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    compare_cnt++;
    if (obs !== exp) begin
      mismatch_cnt++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic expectWindow(input string tag, input window_t w, input logic s, input logic e);
    if (q_win.size() == 0) begin
      checkOutput({tag, " present"}, 72'd0, 72'd1);
    end else begin
      checkOutput({tag, " win"}, q_win.pop_front(), w);
      checkOutput({tag, " sol"}, 72'(q_sol.pop_front()), 72'(s));
      checkOutput({tag, " eol"}, 72'(q_eol.pop_front()), 72'(e));
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst             = 1'b1;
    strm.in_vld     = 1'b0;
    strm.in_col     = '0;
    strm.in_top_vld = 1'b1;
    strm.in_bot_vld = 1'b1;
    strm.in_sol     = 1'b0;
    strm.in_eol     = 1'b0;
    strm.out_rdy    = 1'b1;
    waitCycles(3);
    rst = 1'b0;
    q_win.delete();
    q_sol.delete();
    q_eol.delete();
  endtask

  // Presents one column and holds it until accepted (bounded wait).
  task automatic applyStimulus(input column_t col, input bit tv, input bit bv, input bit sol, input bit eol);
    int n;
    n = 0;
    strm.in_col     = col;
    strm.in_top_vld = tv;
    strm.in_bot_vld = bv;
    strm.in_sol     = sol;
    strm.in_eol     = eol;
    strm.in_vld     = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!strm.in_rdy && n < 50);
    if (!strm.in_rdy) checkOutput("accept timeout", 72'd0, 72'd1);
    @(posedge clk);
    #1;
    strm.in_vld = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    column_t c0, c1, c2, c3, c4, ma, mb;

    doReset();
    @(negedge clk);
    checkOutput("reset out_vld", 72'(strm.out_vld), 72'd0);
    checkOutput("reset in_rdy",  72'(strm.in_rdy),  72'd1);
    checkOutput("reset err",     72'(err),          72'd0);
    checkOutput("reset out_sol", 72'(strm.out_sol), 72'd0);
    checkOutput("reset out_eol", 72'(strm.out_eol), 72'd0);
    waitCycles(1);

    c0 = mkcol(11, 12, 13); c1 = mkcol(21, 22, 23); c2 = mkcol(31, 32, 33);
    applyStimulus(c0, 1, 1, 1, 0);
    applyStimulus(c1, 1, 1, 0, 0);
    applyStimulus(c2, 1, 1, 0, 1);
    waitCycles(4);
    checkOutput("line3 count", 72'(q_win.size()), 72'd3);
    expectWindow("line3 w0", mkwin(edgeOf(c0), c0, c1), 1'b1, 1'b0);
    expectWindow("line3 w1", mkwin(c0, c1, c2), 1'b0, 1'b0);
    expectWindow("line3 w2", mkwin(c1, c2, edgeOf(c2)), 1'b0, 1'b1);
    checkOutput("line3 err", 72'(err), 72'd0);

    c0 = mkcol(5, 6, 7); c1 = mkcol(8, 9, 10);
    ma = maskCol(c0, 0, 1); mb = maskCol(c1, 1, 0);
    applyStimulus(c0, 0, 1, 1, 0);
    applyStimulus(c1, 1, 0, 0, 1);
    waitCycles(4);
    checkOutput("mask count", 72'(q_win.size()), 72'd2);
    expectWindow("mask w0", mkwin(edgeOf(ma), ma, mb), 1'b1, 1'b0);
    expectWindow("mask w1", mkwin(ma, mb, edgeOf(mb)), 1'b0, 1'b1);

    c0 = mkcol(1, 2, 3);
    applyStimulus(c0, 1, 1, 1, 1);
    waitCycles(4);
    checkOutput("width1 count", 72'(q_win.size()), 72'd1);
    expectWindow("width1 w0", mkwin(edgeOf(c0), c0, edgeOf(c0)), 1'b1, 1'b1);

    c0 = mkcol(41, 42, 43); c1 = mkcol(51, 52, 53);
    c2 = mkcol(61, 62, 63); c3 = mkcol(71, 72, 73);
    fork
      begin
        applyStimulus(c0, 1, 1, 1, 0);
        applyStimulus(c1, 1, 1, 0, 0);
        applyStimulus(c2, 1, 1, 0, 0);
        applyStimulus(c3, 1, 1, 0, 1);
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        strm.out_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          checkOutput($sformatf("stall in_rdy %0d", i),  72'(strm.in_rdy),  72'd0);
          checkOutput($sformatf("stall out_vld %0d", i), 72'(strm.out_vld), 72'd1);
          checkOutput($sformatf("stall out_win %0d", i), strm.out_win, mkwin(edgeOf(c0), c0, c1));
        end
        @(posedge clk);
        #1;
        strm.out_rdy = 1'b1;
      end
    join
    waitCycles(4);
    checkOutput("stall count", 72'(q_win.size()), 72'd4);
    expectWindow("stall w0", mkwin(edgeOf(c0), c0, c1), 1'b1, 1'b0);
    expectWindow("stall w1", mkwin(c0, c1, c2), 1'b0, 1'b0);
    expectWindow("stall w2", mkwin(c1, c2, c3), 1'b0, 1'b0);
    expectWindow("stall w3", mkwin(c2, c3, edgeOf(c3)), 1'b0, 1'b1);
    checkOutput("stall err", 72'(err), 72'd0);

    applyStimulus(mkcol(9, 9, 9), 1, 1, 0, 0);
    waitCycles(3);
    checkOutput("nosol err", 72'(err), 72'd1);
    checkOutput("nosol count", 72'(q_win.size()), 72'd0);
    waitCycles(5);
    checkOutput("nosol err sticky", 72'(err), 72'd1);

    // A pending window held by backpressure must vanish on reset.
    strm.out_rdy = 1'b0;
    applyStimulus(mkcol(1, 1, 1), 1, 1, 1, 0);
    applyStimulus(mkcol(2, 2, 2), 1, 1, 0, 0);
    doReset();
    waitCycles(3);
    checkOutput("midreset out_vld", 72'(strm.out_vld), 72'd0);
    checkOutput("midreset count", 72'(q_win.size()), 72'd0);
    checkOutput("midreset err", 72'(err), 72'd0);

    c0 = mkcol(81, 82, 83); c1 = mkcol(91, 92, 93); c2 = mkcol(101, 102, 103);
    c3 = mkcol(111, 112, 113); c4 = mkcol(121, 122, 123);
    applyStimulus(c0, 1, 1, 1, 0);
    applyStimulus(c1, 1, 1, 0, 0);
    applyStimulus(c2, 1, 1, 0, 0);
    applyStimulus(c3, 1, 1, 0, 0);
    applyStimulus(c4, 1, 1, 0, 1);
    waitCycles(4);
    checkOutput("ovf count", 72'(q_win.size()), 72'd4);
    expectWindow("ovf w0", mkwin(edgeOf(c0), c0, c1), 1'b1, 1'b0);
    expectWindow("ovf w1", mkwin(c0, c1, c2), 1'b0, 1'b0);
    expectWindow("ovf w2", mkwin(c1, c2, c3), 1'b0, 1'b0);
    expectWindow("ovf w3", mkwin(c2, c3, edgeOf(c3)), 1'b0, 1'b1);
    checkOutput("ovf err", 72'(err), 72'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_cnt, mismatch_cnt);
    $finish;
  end

endmodule
